// File: rtl/pid_mixer_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
//   Shared types and constants for the heading-control mixer:
//   - mixer_state_t : forward-speed ramp FSM states
//   - SPD_MAX/SPD_MIN : 12-bit signed wheel-command limits
//   - term / datapath widths used by pid_mixer and sat_signed
// ---------------------------------------------------------------------------
package pid_pkg;

  localparam int P_W   = 14;  // proportional term width
  localparam int I_W   = 12;  // integral term width
  localparam int D_W   = 15;  // derivative term width
  localparam int SUM_W = 16;  // PID sum width
  localparam int RAW_W = 17;  // pre-saturation mix width
  localparam int SPD_W = 12;  // wheel command width
  localparam int FWD_W = 11;  // forward-speed width

  localparam logic signed [SPD_W-1:0] SPD_MAX = 12'sd2047;
  localparam logic signed [SPD_W-1:0] SPD_MIN = -12'sd2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    CRUISE    = 2'd2,
    RAMP_DOWN = 2'd3
  } mixer_state_t;

endpackage

// File: rtl/pid_mixer_sat_signed.sv
// ---------------------------------------------------------------------------
// sat_signed
//   Clamps a 17-bit signed value into the 12-bit signed wheel-command range.
//   Ports:
//     din  in  17 signed value to clamp
//     dout out 12 clamped value in [SPD_MIN, SPD_MAX]
//     sat  out 1  high when din was outside the range
// ---------------------------------------------------------------------------
module sat_signed
  import pid_pkg::*;
(
  input  logic [RAW_W-1:0] din,
  output logic [SPD_W-1:0] dout,
  output logic             sat
);

  logic signed [RAW_W-1:0] din_s;

  assign din_s = $signed(din);

  // Range compare against the 12-bit limits, sign-extended to 17 bits
  always_comb begin
    dout = din[SPD_W-1:0];
    sat  = 1'b0;
    if (din_s > 17'sd2047) begin
      dout = SPD_MAX;
      sat  = 1'b1;
    end else if (din_s < -17'sd2048) begin
      dout = SPD_MIN;
      sat  = 1'b1;
    end else begin
      dout = din[SPD_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/pid_mixer.sv
// ---------------------------------------------------------------------------
// pid_mixer
//   Sums the P, I and D heading terms, scales the sum by an arithmetic right
//   shift, ramps a forward-speed base toward frwrd_tgt and mixes both into
//   saturated left/right wheel commands. One update per err_vld; spd_vld
//   pulses three cycles after the err_vld that started the update.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     err_vld              update strobe (P/I valid now, D one cycle later)
//     P_term/I_term/D_term signed heading terms (14/12/15 bits)
//     moving, frwrd_tgt    drive enable and unsigned forward target
//     lft_spd, rght_spd    registered signed wheel commands
//     spd_vld              one-cycle strobe with each command update
//     at_speed             high while the ramp FSM is in CRUISE
//     sat_cnt              (MIXER_SAT_CNT_EN only) count of saturated updates
//
//   Build option: define MIXER_SAT_CNT_EN to add the saturation counter.
// ---------------------------------------------------------------------------
module pid_mixer
  import pid_pkg::*;
#(
  parameter int unsigned RAMP_INC  = 16,
  parameter int unsigned RAMP_DEC  = 32,
  parameter int unsigned PID_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err_vld,
  input  logic [P_W-1:0]   P_term,
  input  logic [I_W-1:0]   I_term,
  input  logic [D_W-1:0]   D_term,
  input  logic             moving,
  input  logic [FWD_W-1:0] frwrd_tgt,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld,
`ifdef MIXER_SAT_CNT_EN
  output logic [7:0]       sat_cnt,
`endif
  output logic             at_speed
);

  localparam logic [FWD_W:0]   INC_C = 12'(RAMP_INC);
  localparam logic [FWD_W-1:0] DEC_C = 11'(RAMP_DEC);

  // Alignment and stage-1 state
  logic                    vld_d1_r;
  logic                    vld_d2_r;
  logic [P_W-1:0]          p_r;
  logic [I_W-1:0]          i_r;
  logic signed [SUM_W-1:0] pid_sum_r;
  logic [FWD_W-1:0]        frwrd_r;
  mixer_state_t            state_r;
  logic                    at_speed_r;

  // Stage-2 outputs
  logic [SPD_W-1:0]        lft_spd_r;
  logic [SPD_W-1:0]        rght_spd_r;
  logic                    spd_vld_r;

  // Combinational helpers
  logic signed [SUM_W-1:0] pid_sum_s;
  logic signed [SUM_W-1:0] pid_shf_s;
  logic [FWD_W:0]          tgt_ext_s;
  logic [FWD_W:0]          up_sum_s;
  logic                    up_hit_s;
  logic [FWD_W-1:0]        up_val_s;
  logic                    dn0_zero_s;
  logic [FWD_W-1:0]        dn0_val_s;
  logic [FWD_W:0]          tgt_dec_s;
  logic [FWD_W-1:0]        dnt_val_s;
  mixer_state_t            state_nxt_s;
  logic [FWD_W-1:0]        frwrd_nxt_s;
  logic                    clr_sat_s;
  logic signed [RAW_W-1:0] fwd_ext_s;
  logic signed [RAW_W-1:0] pid_ext_s;
  logic signed [RAW_W-1:0] lft_raw_s;
  logic signed [RAW_W-1:0] rght_raw_s;
  logic [SPD_W-1:0]        lft_sat_s;
  logic [SPD_W-1:0]        rght_sat_s;
  logic                    lft_flag_s;
  logic                    rght_flag_s;

  // P and I are latched on err_vld; D arrives one cycle later straight
  // from the upstream pipeline, so all three line up when vld_d1_r is high.
  assign pid_sum_s = $signed({{(SUM_W-P_W){p_r[P_W-1]}}, p_r})
                   + $signed({{(SUM_W-I_W){i_r[I_W-1]}}, i_r})
                   + $signed({{(SUM_W-D_W){D_term[D_W-1]}}, D_term});
  assign pid_shf_s = pid_sum_s >>> PID_SHIFT;

  // Ramp arithmetic: up-step clamped to target, down-step clamped to 0 or target
  assign tgt_ext_s  = {1'b0, frwrd_tgt};
  assign up_sum_s   = {1'b0, frwrd_r} + INC_C;
  assign up_hit_s   = (up_sum_s >= tgt_ext_s);
  assign up_val_s   = up_hit_s ? frwrd_tgt : up_sum_s[FWD_W-1:0];
  assign dn0_zero_s = (frwrd_r <= DEC_C);
  assign dn0_val_s  = dn0_zero_s ? 11'd0 : (frwrd_r - DEC_C);
  assign tgt_dec_s  = tgt_ext_s + {1'b0, DEC_C};
  assign dnt_val_s  = ({1'b0, frwrd_r} >= tgt_dec_s) ? (frwrd_r - DEC_C) : frwrd_tgt;

  // Ramp FSM next-state and next forward speed
  always_comb begin
    state_nxt_s = state_r;
    frwrd_nxt_s = frwrd_r;
    clr_sat_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (moving) begin
          state_nxt_s = RAMP_UP;
          frwrd_nxt_s = up_val_s;
          clr_sat_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          frwrd_nxt_s = 11'd0;
        end
      end
      RAMP_UP: begin
        if (!moving) begin
          state_nxt_s = RAMP_DOWN;
          frwrd_nxt_s = frwrd_r;
        end else begin
          state_nxt_s = up_hit_s ? CRUISE : RAMP_UP;
          frwrd_nxt_s = up_val_s;
        end
      end
      CRUISE: begin
        if (!moving) begin
          state_nxt_s = dn0_zero_s ? IDLE : RAMP_DOWN;
          frwrd_nxt_s = dn0_val_s;
        end else if (frwrd_tgt > frwrd_r) begin
          state_nxt_s = up_hit_s ? CRUISE : RAMP_UP;
          frwrd_nxt_s = up_val_s;
        end else if (frwrd_tgt < frwrd_r) begin
          state_nxt_s = CRUISE;
          frwrd_nxt_s = dnt_val_s;
        end else begin
          state_nxt_s = CRUISE;
          frwrd_nxt_s = frwrd_r;
        end
      end
      RAMP_DOWN: begin
        if (moving) begin
          state_nxt_s = up_hit_s ? CRUISE : RAMP_UP;
          frwrd_nxt_s = up_val_s;
        end else begin
          state_nxt_s = dn0_zero_s ? IDLE : RAMP_DOWN;
          frwrd_nxt_s = dn0_val_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        frwrd_nxt_s = 11'd0;
      end
    endcase
  end

  // Alignment pipeline, term capture and stage-1 (PID sum, ramp FSM)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d1_r   <= 1'b0;
      vld_d2_r   <= 1'b0;
      p_r        <= 14'd0;
      i_r        <= 12'd0;
      pid_sum_r  <= 16'sd0;
      frwrd_r    <= 11'd0;
      state_r    <= IDLE;
      at_speed_r <= 1'b0;
    end else begin
      vld_d1_r <= err_vld;
      vld_d2_r <= vld_d1_r;
      if (err_vld) begin
        p_r <= P_term;
        i_r <= I_term;
      end
      if (vld_d1_r) begin
        pid_sum_r  <= pid_shf_s;
        frwrd_r    <= frwrd_nxt_s;
        state_r    <= state_nxt_s;
        at_speed_r <= (state_nxt_s == CRUISE);
      end
    end
  end

  // Stage-2 mix in 17 bits so frwrd +/- pid_sum cannot wrap before clamping
  assign fwd_ext_s  = $signed({6'd0, frwrd_r});
  assign pid_ext_s  = $signed({pid_sum_r[SUM_W-1], pid_sum_r});
  assign lft_raw_s  = fwd_ext_s + pid_ext_s;
  assign rght_raw_s = fwd_ext_s - pid_ext_s;

  sat_signed u_sat_lft (
    .din  (lft_raw_s),
    .dout (lft_sat_s),
    .sat  (lft_flag_s)
  );

  sat_signed u_sat_rght (
    .din  (rght_raw_s),
    .dout (rght_sat_s),
    .sat  (rght_flag_s)
  );

  // Stage-2 output registers; IDLE forces a stopped command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd_r  <= 12'd0;
      rght_spd_r <= 12'd0;
      spd_vld_r  <= 1'b0;
    end else begin
      spd_vld_r <= vld_d2_r;
      if (vld_d2_r) begin
        if (state_r == IDLE) begin
          lft_spd_r  <= 12'd0;
          rght_spd_r <= 12'd0;
        end else begin
          lft_spd_r  <= lft_sat_s;
          rght_spd_r <= rght_sat_s;
        end
      end
    end
  end

  assign lft_spd  = lft_spd_r;
  assign rght_spd = rght_spd_r;
  assign spd_vld  = spd_vld_r;
  assign at_speed = at_speed_r;

`ifdef MIXER_SAT_CNT_EN
  logic [7:0] sat_cnt_r;

  // Saturation event counter: one count per saturated update, sticky at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= 8'd0;
    end else if (vld_d1_r && clr_sat_s) begin
      sat_cnt_r <= 8'd0;
    end else if (vld_d2_r && (state_r != IDLE) && (lft_flag_s || rght_flag_s) &&
                 (sat_cnt_r != 8'd255)) begin
      sat_cnt_r <= sat_cnt_r + 8'd1;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign sat_cnt = sat_cnt_r;
`endif

endmodule

// File: tb/tb_pid_mixer.sv
// ---------------------------------------------------------------------------
// tb_pid_mixer
//   Directed self-checking bench for pid_mixer (default parameters:
//   RAMP_INC=16, RAMP_DEC=32, PID_SHIFT=3). Expected values are computed by
//   hand from the ramp/mix rules. Define MIXER_SAT_CNT_EN to also check
//   the saturation counter.
// ---------------------------------------------------------------------------
module tb_pid_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_vld;
  logic [13:0] P_term;
  logic [11:0] I_term;
  logic [14:0] D_term;
  logic        moving;
  logic [10:0] frwrd_tgt;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        spd_vld;
  logic        at_speed;
`ifdef MIXER_SAT_CNT_EN
  logic [7:0]  sat_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Values captured by do_update
  logic [3:0]         cap_pat;
  logic signed [11:0] cap_l;
  logic signed [11:0] cap_r;
  logic               cap_at;

  pid_mixer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_vld   (err_vld),
    .P_term    (P_term),
    .I_term    (I_term),
    .D_term    (D_term),
    .moving    (moving),
    .frwrd_tgt (frwrd_tgt),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .spd_vld   (spd_vld),
`ifdef MIXER_SAT_CNT_EN
    .sat_cnt   (sat_cnt),
`endif
    .at_speed  (at_speed)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One update: err_vld with P/I, D one cycle later, junk elsewhere.
  // cap_pat holds spd_vld after edges E0..E3; expected 4'b0010.
  task automatic do_update(input logic [13:0] p, input logic [11:0] i, input logic [14:0] d);
    @(negedge clk); err_vld = 1'b1; P_term = p; I_term = i; D_term = 15'h2AAA;
    @(negedge clk); err_vld = 1'b0; D_term = d; P_term = 14'h1555; I_term = 12'h0AA;
    cap_pat[3] = spd_vld;
    @(negedge clk); D_term = 15'h2AAA; cap_pat[2] = spd_vld;
    @(negedge clk); cap_pat[1] = spd_vld;
    cap_l = $signed(lft_spd); cap_r = $signed(rght_spd); cap_at = at_speed;
    @(negedge clk); cap_pat[0] = spd_vld;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0; err_vld = 1'b0; P_term = 14'd0; I_term = 12'd0; D_term = 15'd0;
    moving = 1'b0; frwrd_tgt = 11'd0;
    repeat (3) @(negedge clk);
    n_chk++; if (lft_spd !== 12'd0) begin n_fail++; $display("FAIL reset_lft: got %0d want 0", lft_spd); end
    n_chk++; if (rght_spd !== 12'd0) begin n_fail++; $display("FAIL reset_rght: got %0d want 0", rght_spd); end
    n_chk++; if (spd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", spd_vld); end
    n_chk++; if (at_speed !== 1'b0) begin n_fail++; $display("FAIL reset_at_speed: got %b want 0", at_speed); end
`ifdef MIXER_SAT_CNT_EN
    n_chk++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
`endif
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (spd_vld === 1'b1) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_vld: spd_vld seen=%b want 0", seen); end
  endtask

  task automatic test_ramp_up();
    logic signed [11:0] exp_l [0:2] = '{12'sd16, 12'sd32, 12'sd48};
    logic               exp_a [0:2] = '{1'b0, 1'b0, 1'b1};
    moving = 1'b1; frwrd_tgt = 11'd48;
    for (int k = 0; k < 3; k++) begin
      do_update(14'd0, 12'd0, 15'd0);
      n_chk++; if (cap_pat !== 4'b0010) begin n_fail++; $display("FAIL ramp_up_latency[%0d]: got %b want 0010", k, cap_pat); end
      n_chk++; if (cap_l !== exp_l[k] || cap_r !== exp_l[k]) begin n_fail++;
        $display("FAIL ramp_up_spd[%0d]: got %0d/%0d want %0d/%0d", k, cap_l, cap_r, exp_l[k], exp_l[k]); end
      n_chk++; if (cap_at !== exp_a[k]) begin n_fail++; $display("FAIL ramp_up_at_speed[%0d]: got %b want %b", k, cap_at, exp_a[k]); end
    end
  endtask

  task automatic test_pid_mix();
    frwrd_tgt = 11'd512;
    cap_at = 1'b0;
    do_update(14'd0, 12'd0, 15'd0);
    for (int k = 0; k < 40 && cap_at !== 1'b1; k++) do_update(14'd0, 12'd0, 15'd0);
    n_chk++; if (cap_at !== 1'b1 || cap_l !== 12'sd512) begin n_fail++;
      $display("FAIL cruise_512: got at_speed=%b lft=%0d want 1/512", cap_at, cap_l); end
    // 100+20-56 = 64 -> 8
    do_update(14'd100, 12'd20, -15'sd56);
    n_chk++; if (cap_l !== 12'sd520 || cap_r !== 12'sd504) begin n_fail++;
      $display("FAIL mix_pos: got %0d/%0d want 520/504", cap_l, cap_r); end
    // -64 -> -8
    do_update(-14'sd100, -12'sd20, 15'sd56);
    n_chk++; if (cap_l !== 12'sd504 || cap_r !== 12'sd520) begin n_fail++;
      $display("FAIL mix_neg: got %0d/%0d want 504/520", cap_l, cap_r); end
    // -3 >>> 3 = -1 (arithmetic shift rounds toward -inf)
    do_update(-14'sd3, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd511 || cap_r !== 12'sd513) begin n_fail++;
      $display("FAIL mix_asr: got %0d/%0d want 511/513", cap_l, cap_r); end
    // max terms: 26621 >>> 3 = 3327 -> both sides saturate
    do_update(14'sd8191, 12'sd2047, 15'sd16383);
    n_chk++; if (cap_l !== 12'sd2047 || cap_r !== -12'sd2048) begin n_fail++;
      $display("FAIL mix_max_terms: got %0d/%0d want 2047/-2048", cap_l, cap_r); end
`ifdef MIXER_SAT_CNT_EN
    n_chk++; if (sat_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_cnt_first: got %0d want 1", sat_cnt); end
`endif
  endtask

  task automatic test_saturation();
    frwrd_tgt = 11'd1792;
    cap_at = 1'b0;
    do_update(14'd0, 12'd0, 15'd0);
    for (int k = 0; k < 100 && cap_at !== 1'b1; k++) do_update(14'd0, 12'd0, 15'd0);
    n_chk++; if (cap_at !== 1'b1 || cap_l !== 12'sd1792) begin n_fail++;
      $display("FAIL cruise_1792: got at_speed=%b lft=%0d want 1/1792", cap_at, cap_l); end
    // 4000 >>> 3 = 500
    do_update(14'd4000, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd2047 || cap_r !== 12'sd1292) begin n_fail++;
      $display("FAIL sat_pos: got %0d/%0d want 2047/1292", cap_l, cap_r); end
`ifdef MIXER_SAT_CNT_EN
    n_chk++; if (sat_cnt !== 8'd2) begin n_fail++; $display("FAIL sat_cnt_inc: got %0d want 2", sat_cnt); end
`endif
  endtask

  task automatic test_ramp_down();
    logic signed [11:0] dn_l [0:3] = '{12'sd68, 12'sd36, 12'sd4, 12'sd0};
    logic signed [11:0] up_l [0:6] = '{12'sd16, 12'sd32, 12'sd48, 12'sd64, 12'sd80, 12'sd96, 12'sd100};
    logic signed [11:0] rv_l [0:5] = '{12'sd68, 12'sd36, 12'sd52, 12'sd68, 12'sd84, 12'sd100};
    logic               rv_m [0:5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // target drop while cruising: frwrd steps down by 32, clamped at target
    frwrd_tgt = 11'd100;
    cap_l = 12'sd0;
    do_update(14'd0, 12'd0, 15'd0);
    for (int k = 0; k < 70 && cap_l !== 12'sd100; k++) do_update(14'd0, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd100 || cap_at !== 1'b1) begin n_fail++;
      $display("FAIL cruise_100: got lft=%0d at_speed=%b want 100/1", cap_l, cap_at); end
    // -26624 >>> 3 = -3328: lft low-saturates, rght high-saturates, one count
    do_update(-14'sd8192, -12'sd2048, -15'sd16384);
    n_chk++; if (cap_l !== -12'sd2048 || cap_r !== 12'sd2047) begin n_fail++;
      $display("FAIL sat_both: got %0d/%0d want -2048/2047", cap_l, cap_r); end
`ifdef MIXER_SAT_CNT_EN
    n_chk++; if (sat_cnt !== 8'd3) begin n_fail++; $display("FAIL sat_cnt_both: got %0d want 3", sat_cnt); end
`endif
    moving = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_update(14'd0, 12'd0, 15'd0);
      n_chk++; if (cap_l !== dn_l[k] || cap_r !== dn_l[k] || cap_at !== 1'b0 || cap_pat !== 4'b0010) begin n_fail++;
        $display("FAIL ramp_down[%0d]: got %0d/%0d at=%b pat=%b want %0d/%0d at=0 pat=0010",
                 k, cap_l, cap_r, cap_at, cap_pat, dn_l[k], dn_l[k]); end
    end
    // IDLE ignores PID but still strobes
    do_update(14'd800, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd0 || cap_r !== 12'sd0 || cap_pat !== 4'b0010) begin n_fail++;
      $display("FAIL idle_forced_zero: got %0d/%0d pat=%b want 0/0 pat=0010", cap_l, cap_r, cap_pat); end
    moving = 1'b1;
    for (int k = 0; k < 7; k++) begin
      do_update(14'd0, 12'd0, 15'd0);
      n_chk++; if (cap_l !== up_l[k]) begin n_fail++;
        $display("FAIL restart[%0d]: got %0d want %0d", k, cap_l, up_l[k]); end
`ifdef MIXER_SAT_CNT_EN
      if (k == 0) begin
        n_chk++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_cnt_clear: got %0d want 0", sat_cnt); end
      end
`endif
    end
    n_chk++; if (cap_at !== 1'b1) begin n_fail++; $display("FAIL restart_at_speed: got %b want 1", cap_at); end
    // drop, then reassert moving at frwrd=36
    for (int k = 0; k < 6; k++) begin
      moving = rv_m[k];
      do_update(14'd0, 12'd0, 15'd0);
      n_chk++; if (cap_l !== rv_l[k]) begin n_fail++;
        $display("FAIL reassert[%0d]: got %0d want %0d", k, cap_l, rv_l[k]); end
    end
    n_chk++; if (cap_at !== 1'b1) begin n_fail++; $display("FAIL reassert_at_speed: got %b want 1", cap_at); end
  endtask

  task automatic test_back_to_back();
    logic               v [0:6];
    logic signed [11:0] l [0:6];
    logic signed [11:0] r [0:6];
    logic signed [11:0] el [0:2] = '{12'sd110, 12'sd120, 12'sd90};
    logic signed [11:0] er [0:2] = '{12'sd90, 12'sd80, 12'sd110};
    @(negedge clk); err_vld = 1'b1; P_term = 14'd80; I_term = 12'd0; D_term = 15'h2AAA;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      case (j)
        0: begin P_term = 14'd160; D_term = 15'd0; end
        1: begin P_term = -14'sd80; D_term = 15'd0; end
        2: begin err_vld = 1'b0; P_term = 14'h1555; D_term = 15'd0; end
        default: D_term = 15'h2AAA;
      endcase
      v[j] = spd_vld; l[j] = $signed(lft_spd); r[j] = $signed(rght_spd);
    end
    for (int j = 0; j < 7; j++) begin
      n_chk++;
      if ((j >= 2 && j <= 4) ? (v[j] !== 1'b1 || l[j] !== el[j-2] || r[j] !== er[j-2]) : (v[j] !== 1'b0)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got vld=%b %0d/%0d want vld=%b %0d/%0d", j, v[j], l[j], r[j],
                 (j >= 2 && j <= 4), (j >= 2 && j <= 4) ? el[j-2] : 12'sd0, (j >= 2 && j <= 4) ? er[j-2] : 12'sd0);
      end
    end
  endtask

  task automatic test_reset_midramp();
    logic seen;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    moving = 1'b1; frwrd_tgt = 11'd100;
    do_update(14'd0, 12'd0, 15'd0);
    do_update(14'd0, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd32) begin n_fail++; $display("FAIL midramp_setup: got %0d want 32", cap_l); end
    @(negedge clk); err_vld = 1'b1; P_term = 14'd0; I_term = 12'd0;
    @(negedge clk); err_vld = 1'b0; D_term = 15'd0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (lft_spd !== 12'd0 || rght_spd !== 12'd0 || spd_vld !== 1'b0 || at_speed !== 1'b0) begin n_fail++;
      $display("FAIL midramp_async_clear: got %0d/%0d vld=%b at=%b want 0/0 0 0", lft_spd, rght_spd, spd_vld, at_speed); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (spd_vld === 1'b1) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midramp_no_vld: seen=%b want 0", seen); end
    do_update(14'd0, 12'd0, 15'd0);
    n_chk++; if (cap_l !== 12'sd16 || cap_pat !== 4'b0010) begin n_fail++;
      $display("FAIL midramp_restart: got %0d pat=%b want 16 pat=0010", cap_l, cap_pat); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_pid_mix();
    test_saturation();
    test_ramp_down();
    test_back_to_back();
    test_reset_midramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
